// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: groups the pixel-tick, colour-source and display signals of vga_timing_gen
//   master (the generator): takes i_ce, i_pattern, i_r/g/b; drives o_x, o_y, o_de_req, o_vga_*, o_de, o_frame_start
//   slave (the colour source / display): the mirror image
interface vga_timing_gen_if #(
    parameter int CW = 4,
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          i_ce;
    logic          i_pattern;
    logic [CW-1:0] i_r, i_g, i_b;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic          o_de_req;
    logic          o_vga_hs, o_vga_vs;
    logic [CW-1:0] o_vga_r, o_vga_g, o_vga_b;
    logic          o_de;
    logic          o_frame_start;
    modport master (
        input  i_ce, i_pattern, i_r, i_g, i_b,
        output o_x, o_y, o_de_req, o_vga_hs, o_vga_vs, o_vga_r, o_vga_g, o_vga_b, o_de, o_frame_start
    );
    modport slave (
        output i_ce, i_pattern, i_r, i_g, i_b,
        input  o_x, o_y, o_de_req, o_vga_hs, o_vga_vs, o_vga_r, o_vga_g, o_vga_b, o_de, o_frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blanking generator with latency-matched colour path and colour-bar pattern
//   clk_vga, rst_vga (sync, active-high): clock and reset
//   bus (vga_timing_gen_if.master): pixel tick enable, colour source request/return, display outputs
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_LAT = 1,
    parameter int CW       = 4,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input logic clk_vga,
    input logic rst_vga,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    // per-pixel control travelling alongside the colour source latency; hs/vs are "sync asserted" flags
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       pat;
        logic [2:0] c;
    } ctrl_t;

    logic [XW-1:0] h_q, h_d, bc_q, bc_d;
    logic [YW-1:0] v_q, v_d;
    logic [2:0]    bar_q, bar_d;
    logic          h_wrap, step;
    ctrl_t         ctrl, tail;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    always_comb begin
        h_wrap = h_q == H_LAST;
        step   = h_q < H_ACT && bc_q == BAR_LAST;
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = !h_wrap ? v_q : v_q == V_LAST ? '0 : v_q + 1'b1;
        bc_d   = h_wrap || step ? '0 : h_q < H_ACT ? bc_q + 1'b1 : bc_q;
        bar_d  = h_wrap ? '0 : step && bar_q != 3'd7 ? bar_q + 1'b1 : bar_q;
    end

    always_comb begin
        ctrl.de  = h_q < H_ACT && v_q < V_ACT;
        ctrl.hs  = h_q >= HS_BEG && h_q < HS_END;
        ctrl.vs  = v_q >= VS_BEG && v_q < VS_END;
        ctrl.fs  = h_q == '0 && v_q == '0;
        ctrl.pat = bus.i_pattern;
        ctrl.c   = 3'd7 - bar_q;
    end

    if (PIPE_LAT == 0) begin : g_nodl
        assign tail = ctrl;
    end else begin : g_dl
        ctrl_t dl_q [PIPE_LAT];
        ctrl_t dl_d [PIPE_LAT];
        always_comb begin
            dl_d[0] = ctrl;
            for (int i = 1; i < PIPE_LAT; i++) dl_d[i] = dl_q[i-1];
        end
        always_ff @(posedge clk_vga) begin
            if (rst_vga) begin
                for (int i = 0; i < PIPE_LAT; i++) dl_q[i] <= '0;
            end else if (bus.i_ce) begin
                dl_q <= dl_d;
            end
        end
        assign tail = dl_q[PIPE_LAT-1];
    end

    // blanking forces black, so the pattern and pass-through paths only matter while de is set
    always_comb begin
        de_d = tail.de;
        fs_d = tail.fs;
        hs_d = tail.hs ? HS_POL : ~HS_POL;
        vs_d = tail.vs ? VS_POL : ~VS_POL;
        r_d  = !tail.de ? '0 : tail.pat ? {CW{tail.c[2]}} : bus.i_r;
        g_d  = !tail.de ? '0 : tail.pat ? {CW{tail.c[1]}} : bus.i_g;
        b_d  = !tail.de ? '0 : tail.pat ? {CW{tail.c[0]}} : bus.i_b;
    end

    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            h_q   <= '0;
            v_q   <= '0;
            bc_q  <= '0;
            bar_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
        end else if (bus.i_ce) begin
            h_q   <= h_d;
            v_q   <= v_d;
            bc_q  <= bc_d;
            bar_q <= bar_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            fs_q  <= fs_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
        end
    end

    assign bus.o_x           = h_q;
    assign bus.o_y           = v_q;
    assign bus.o_de_req      = h_q < H_ACT && v_q < V_ACT;
    assign bus.o_vga_hs      = hs_q;
    assign bus.o_vga_vs      = vs_q;
    assign bus.o_vga_r       = r_q;
    assign bus.o_vga_g       = g_q;
    assign bus.o_vga_b       = b_q;
    assign bus.o_de          = de_q;
    assign bus.o_frame_start = fs_q;
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 (horizontal pixels per region).
REQ-002 The block SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (vertical lines per region).
REQ-003 The block SHALL have parameters HS_POL 0 and VS_POL 0, giving the sync level while active (0 = active-low).
REQ-004 The block SHALL have parameter PIPE_LAT 1, the colour-source latency in pixel ticks (legal range 0..15).
REQ-005 The block SHALL have parameters CW 4 (bits per colour), XW 10 and YW 10 (coordinate widths).
REQ-006 The block SHALL have these ports:
- clk_vga  in  1: the single clock.
- rst_vga  in  1: synchronous, active-high reset.
- i_ce  in  1: pixel tick enable.
- i_pattern  in  1: 1 = internal colour bars, 0 = pass-through.
- i_r, i_g, i_b  in  CW: pixel colour.
- o_x  out  XW, o_y  out  YW: counter coordinates requested from the colour source.
- o_de_req  out  1: counter is in the active area.
- o_vga_hs  out  1, o_vga_vs  out  1: sync outputs.
- o_vga_r, o_vga_g, o_vga_b  out  CW: displayed colour.
- o_de  out  1: displayed pixel is active.
- o_frame_start  out  1: displayed pixel is (0,0).

Function
REQ-007 Derived totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-008 Region order SHALL be active, front porch, sync, back porch.
REQ-009 All state, including counters, the delay line and output registers, SHALL advance only on clk_vga edges where i_ce=1; with i_ce=0 every output SHALL hold.
REQ-010 The horizontal counter h SHALL count 0..H_TOTAL-1 and then wrap to 0.
REQ-011 At the h wrap, the vertical counter v SHALL increment; v SHALL wrap from V_TOTAL-1 to 0.
REQ-012 The outputs o_x=h and o_y=v SHALL be driven combinationally from the counter registers, with no clamping in blanking.
REQ-013 o_de_req SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-014 Latency, where interval = span between consecutive ce edges:
- Counter holds (h,v) in interval k.
- i_r/g/b for that pixel SHALL be sampled at the end of interval k+PIPE_LAT.
- o_vga_*, o_de and o_frame_start for that pixel SHALL be visible throughout interval k+PIPE_LAT+1.
REQ-015 Horizontal sync SHALL be active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-016 Vertical sync SHALL be active for the whole of lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-017 Both sync signals SHALL be delayed PIPE_LAT+1 ticks, matching the colour path.
REQ-018 Displayed colour SHALL be 0 whenever the delayed de is 0, regardless of i_r/g/b or i_pattern.
REQ-019 With i_pattern=1, the output SHALL be 8 vertical bars of width BAR_W = H_ACTIVE/8 (integer division).
REQ-020 Bar index i SHALL come from a bar counter that restarts at h=0 and steps every BAR_W active pixels, saturating at 7.
REQ-021 The bar colour SHALL be c = 7-i, with R = all-ones if c[2], G = all-ones if c[1], B = all-ones if c[0], else 0.
REQ-022 The bar colour SHALL follow the same PIPE_LAT+1 alignment as pass-through.
REQ-023 PIPE_LAT=0 SHALL be supported: colour is sampled in the same interval as the counter and displayed one tick later.
REQ-024 o_frame_start SHALL be 1 for exactly the one tick in which displayed pixel (0,0) is presented, and 0 otherwise.
REQ-025 i_pattern changes SHALL take effect for the pixel whose counter interval follows the change; the pattern path SHALL contain no glitch logic.

Reset
REQ-026 rst_vga SHALL take priority over i_ce.
REQ-027 On a clk_vga edge with rst_vga=1: h=0, v=0, the delay line cleared to inactive, o_vga_hs=~HS_POL, o_vga_vs=~VS_POL, colours 0, o_de=0, o_frame_start=0.
REQ-028 Reset asserted mid-frame SHALL restart at (0,0), with the first displayed pixel (0,0) appearing PIPE_LAT+1 ticks after release.
REQ-029 During reset, o_x=0, o_y=0 and o_de_req=1.

Verification (defaults, PIPE_LAT=1, i_ce=1 unless stated)
REQ-030 rst_vga high 2 cycles then low -> o_x=0, o_y=0; hs=vs=1 and rgb=0 before release; o_de=1 and o_frame_start=1 on the 2nd edge after release.
REQ-031 Free run -> o_vga_hs low exactly 96 cycles per 800-cycle line, first low on displayed pixel h=656.
REQ-032 Free run -> o_vga_vs low 1600 cycles starting at displayed line 490; o_frame_start period 420000 cycles.
REQ-033 i_r=i_g=i_b=4'hF, i_pattern=0 -> output FFF for 640 of every 800 cycles on lines 0..479, 000 elsewhere and on lines 480..524.
REQ-034 i_pattern=1 -> displayed pixels 0..79 = FFF, 80..159 = FF0, 160..239 = F0F, 560..639 = 000; blanking 000.
REQ-035 i_ce high one cycle in four -> line period 3200 clk_vga cycles; rst_vga pulsed at h=300 -> next edge o_x=0, o_y=0, all outputs at reset values.
